// File: rtl/x1_serializer_if.sv
// x1_serializer_if: word handshake between an upstream producer and x1_serializer
//   in_valid  producer -> serializer  word available
//   in_ready  serializer -> producer  word accepted on this edge if valid
//   in_data   producer -> serializer  word, only bits [in_len-1:0] are used
//   in_len    producer -> serializer  number of bits to send (1..WIDTH legal)
interface x1_serializer_if #(
    parameter int WIDTH = 64,
    parameter int LEN_W = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;

    modport master (output in_valid, in_data, in_len, input in_ready);
    modport slave  (input in_valid, in_data, in_len, output in_ready);
endinterface

// File: rtl/x1_serializer.sv
// x1_serializer: parallel-to-serial front end, MSB-first, one bit per enabled cycle
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   bus       word handshake (in_valid/in_ready/in_data/in_len)
//   shift_en  advance enable; low holds the current bit
//   x1        registered serial bit
//   x1_valid  x1 carries a payload bit
//   done      one-cycle pulse after the last bit of a word retires
//   len_err   one-cycle pulse when a word with an illegal length is accepted
module x1_serializer #(
    parameter int WIDTH = 64,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    x1_serializer_if.slave      bus,
    input  logic                shift_en,
    output logic                x1,
    output logic                x1_valid,
    output logic                done,
    output logic                len_err
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, load_word;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             legal, xfer, advance, last, x1_n, x1_valid_n;

    assign legal     = bus.in_len != '0 && bus.in_len <= LEN_W'(WIDTH);
    // left-justify so the first bit to send sits in the MSB
    assign load_word = bus.in_data << (LEN_W'(WIDTH) - bus.in_len);
    assign advance   = state == SHIFT && shift_en;
    assign last      = advance && cnt == LEN_W'(1);
    // ready during the last bit lets the next word load with no gap cycle
    assign bus.in_ready = !reset && (state == IDLE || last);
    assign xfer      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            x1       <= 1'b0;
            x1_valid <= 1'b0;
            done     <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            cnt      <= cnt_n;
            x1       <= x1_n;
            x1_valid <= x1_valid_n;
            done     <= last;
            len_err  <= xfer && !legal;
        end
    end

    always_comb begin
        state_n = xfer ? (legal ? SHIFT : IDLE) : (last ? IDLE : state);
        sreg_n  = xfer ? (legal ? load_word : '0) : (advance ? sreg << 1 : sreg);
        cnt_n   = xfer ? (legal ? bus.in_len : '0) : (advance ? cnt - LEN_W'(1) : cnt);
    end

    // x1 mirrors sreg MSB, so the bit after a shift is the current sreg[WIDTH-2]
    always_comb begin
        x1_n       = xfer ? (legal && load_word[WIDTH-1]) : last ? 1'b0 : advance ? sreg[WIDTH-2] : x1;
        x1_valid_n = xfer ? legal : last ? 1'b0 : x1_valid;
    end
endmodule

// File: doc/x1_serializer.md
# x1_serializer

Parallel-to-serial front end for the `fsm` sequence stage. It accepts a word of up to `WIDTH` bits over a valid/ready handshake and shifts it out one bit per enabled cycle on `x1`, with the most significant active bit first. It sits directly upstream of `fsm` and drives that stage's `x1` input from a registered output. A final-bit handoff lets back-to-back words stream with no gap cycles.

## Interface
- `WIDTH`, 64, maximum word length in bits; legal range is 2..64.
- `LEN_W`, `$clog2(WIDTH+1)`, width of the length field.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  serializer can accept a word this cycle.
- `in_data`  in  WIDTH  word to send; only bits `[in_len-1:0]` are used.
- `in_len`  in  LEN_W  number of bits to send; legal range is 1..`WIDTH`.
- `shift_en`  in  1  advance enable; when low, the current bit is held.
- `x1`  out  1  serial bit to the `fsm` stage, registered.
- `x1_valid`  out  1  `x1` carries a payload bit.
- `done`  out  1  one-cycle pulse after the last bit of a word retires.
- `len_err`  out  1  one-cycle pulse when a word with an illegal `in_len` is accepted.

## Operation
- **States:** `IDLE` and `SHIFT`. Internal registers are a shift register `sreg[WIDTH-1:0]` and a remaining-bit counter `cnt[LEN_W-1:0]`.
- **Handshake:**
  - A transfer occurs on a rising edge where `in_valid && in_ready`.
  - Upstream holds `in_data` and `in_len` stable until the transfer.
- **`in_ready` (combinational):**
  - `!reset && (state==IDLE || (state==SHIFT && cnt==1 && shift_en))`.
- **Load:**
  - `sreg <= in_data << (WIDTH-in_len)`, which left-justifies the word.
  - `cnt <= in_len`.
  - `x1 <= in_data[in_len-1]`.
  - `x1_valid <= 1`.
  - Next state is `SHIFT`.
- **SHIFT with `shift_en`=1:**
  - `sreg <= sreg << 1`.
  - `cnt <= cnt-1`.
  - `x1 <= next sreg MSB`.
- **SHIFT with `shift_en`=0:** `x1`, `x1_valid`, `sreg` and `cnt` all hold.
- **Last bit (`cnt`==1 and `shift_en`=1):**
  - `done <= 1`.
  - If a new transfer occurs on the same edge, the new word loads with no gap: `x1_valid` stays 1.
  - Otherwise the next state is `IDLE`, with `x1 <= 0` and `x1_valid <= 0`.
- **Illegal length (`in_len`==0 or `in_len`>`WIDTH`):**
  - The transfer still completes.
  - `len_err <= 1` on the next cycle; no bits are sent.
  - The next state is `IDLE`, with `x1 <= 0` and `x1_valid <= 0`.
  - If the illegal word is accepted on a last-bit edge, `done` and `len_err` pulse together.
- **`in_len`==1:** a single bit is sent. `in_ready` asserts during that bit's cycle whenever `shift_en`=1.
- **Unused bits:** `in_data` bits at or above `in_len` are ignored.
- **`shift_en` in IDLE:** ignored. Loading does not depend on `shift_en`.

## Timing
- **Reset values:**
  - `x1`=0, `x1_valid`=0, `done`=0, `len_err`=0.
  - `in_ready`=0 while `reset` is high; it is 1 from the first cycle after deassertion.
  - state=`IDLE`, `cnt`=0, `sreg`=0.
- **Reset mid-word:** outputs clear immediately and asynchronously. The partial word is dropped and no `done` pulse is produced.
- **Latency:** the first bit appears on `x1` in the cycle after the accepting edge.
- **Word duration:** a word of N bits occupies exactly N cycles when `shift_en`=1 throughout. Each cycle with `shift_en`=0 extends it by one cycle.
- **`done`:** high for exactly one cycle, namely the cycle after the last bit's retiring edge.
- **Sampling by `fsm`:** `fsm` samples `x1` on the rising edge that ends each bit cycle.
- **Throughput:** with `in_valid` held high and `shift_en`=1, output is one bit per cycle with zero idle cycles between words.

## Test plan
- **Basic word:** after reset, send `in_data`=8'hA5 with `in_len`=8 and `shift_en`=1.
  - `x1` = 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after acceptance.
  - `done` pulses on the 9th cycle; `x1_valid` is high for exactly 8 cycles.
- **Back-to-back:** `in_data`=3'b110 with `in_len`=3, immediately followed by `in_data`=2'b01 with `in_len`=2.
  - `x1` = 1,1,0,0,1 with no gap cycle.
  - `done` pulses twice; `in_ready` is high on the third bit cycle.
- **Stall:** `in_data`=4'b1001 with `in_len`=4, and `shift_en` low for 3 cycles during the second bit.
  - The second bit (0) holds for 4 cycles.
  - The total word lasts 7 cycles and `done` pulses once at the end.
- **Length boundaries:**
  - `in_len`=1 with `in_data[0]`=1 → one cycle of `x1`=1, then `done`.
  - `in_len`=64 with `in_data`=64'h8000_0000_0000_0001 → 1, then 62 zeros, then 1.
  - `in_len`=0 → `len_err` pulses, `x1_valid` stays 0, and the block is back in `IDLE` and ready on the next cycle.
- **Reset mid-word:** assert `reset` during the 5th bit of a 16-bit word.
  - `x1` and `x1_valid` go to 0 asynchronously and no `done` pulse is produced.
  - After deassertion, the next accepted word is serialized correctly from its MSB.
- **Random stream:** random words, lengths 1..64 and random `shift_en` over 1000 words.
  - A scoreboard compares the sequence of `x1` values taken while `x1_valid`=1 and `shift_en`=1 against the concatenated expected bits.
  - The number of `done` pulses equals the number of legal words.
